// File: rtl/relu_backward01.sv
// ReLU backward gate: stores one sign mask per forward sample in an in-order FIFO
// and applies it to the matching gradient vector. Build option: RELU_BWD_LEAKY_EN.
module relu_backward01 #(
  parameter int W          = 8,
  parameter int LAYER      = 10,
  parameter int DEPTH      = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         fwd_valid,
  input  logic [LAYER*W-1:0]           fwd_data,
  input  logic                         grad_valid,
  input  logic [LAYER*W-1:0]           grad_in,
  output logic                         grad_ready,
  output logic                         valid_out,
  output logic [LAYER*W-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0]   mask_count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
`ifdef RELU_BWD_LEAKY_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  // Handshake: a gradient is consumed on a rising edge where grad_valid && grad_ready;
  // grad_ready depends only on registered state and flush, never on grad_valid.

  logic [LAYER-1:0]   mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               vld_q, vld_d;
  logic [LAYER*W-1:0] dout_q, dout_d;

  logic               push, pop, drop, under;
  logic [LAYER-1:0]   fwd_mask;
  logic [LAYER-1:0]   pop_mask;
  logic [LAYER*W-1:0] gated;

  always_comb begin
    for (int i = 0; i < LAYER; i++) begin
      fwd_mask[i] = ~fwd_data[i*W + W - 1];
    end
  end

  always_comb begin
    grad_ready = (count_q != '0) && !flush;
    pop        = grad_valid && grad_ready;
    push       = fwd_valid && !flush && ((count_q < CW'(DEPTH)) || pop);
    drop       = fwd_valid && !flush && !push;
    under      = grad_valid && !flush && (count_q == '0);
  end

  assign pop_mask = mem_q[rd_ptr_q];

  // Masked lanes are zeroed, or attenuated by an arithmetic shift in the leaky build.
  always_comb begin
    logic signed [W-1:0] lane;
    logic signed [W-1:0] leak;
    gated = '0;
    for (int i = 0; i < LAYER; i++) begin
      lane = grad_in[i*W +: W];
      leak = lane >>> LEAK_SHIFT;
      if (pop_mask[i]) begin
        gated[i*W +: W] = lane;
      end else if (LEAKY) begin
        gated[i*W +: W] = leak;
      end else begin
        gated[i*W +: W] = '0;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    vld_d    = pop;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        dout_d   = gated;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
      if (under) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      vld_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      vld_q    <= vld_d;
      dout_q   <= dout_d;
    end
  end

  // Mask storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fwd_mask;
    end
  end

  assign valid_out  = vld_q;
  assign data_out   = dout_q;
  assign mask_count = count_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule
